// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulate / requantise path.
// Contents:
//   PSUM_W_DEF, OUT_W_DEF : default partial-sum and output lane widths
//   SAT_W                 : working width used by the requant arithmetic
//   lane_lsb()            : bit offset of a lane inside a packed lane vector
//   sat_shift()           : optional ReLU, arithmetic right shift, then signed
//                           saturation to out_w bits (result sign-extended)
package psum_pkg;

    localparam int PSUM_W_DEF = 32;
    localparam int OUT_W_DEF  = 8;
    localparam int SAT_W      = 64;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] value,
        input logic        [7:0]       shift,
        input logic                    relu,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] q;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        r  = (relu && (value < 0)) ? '0 : value;
        q  = r >>> shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (q > hi) begin
            q = hi;
        end else if (q < lo) begin
            q = lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/psum_accum_array_requant.sv
// Combinational requantiser for one lane: ReLU (optional), arithmetic right
// shift and signed saturation of a partial sum down to OUT_W bits.
// Ports:
//   sum_in    : signed partial sum, PSUM_W bits
//   relu_en   : clamp negative sums to zero before shifting
//   shift_amt : arithmetic right shift amount
//   q_out     : saturated signed result, OUT_W bits
module psum_requant
    import psum_pkg::*;
#(
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = 5
) (
    input  logic [PSUM_W-1:0]  sum_in,
    input  logic               relu_en,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic [OUT_W-1:0]   q_out
);

    logic signed [SAT_W-1:0] sat_full;

    always_comb begin
        sat_full = sat_shift(SAT_W'($signed(sum_in)), 8'(shift_amt), relu_en, OUT_W);
    end

    // Saturation already bounded the value to OUT_W bits; keep the low bits.
    assign q_out = OUT_W'(sat_full);

endmodule

// File: rtl/psum_accum_array.sv
// Accumulates LANES partial sums per pixel into external scratch memory across
// input channels. The first channel starts from a per-lane bias (loaded via a
// shift chain); the last channel is requantised and packed into one output
// word behind a valid/ready output register plus a 1-entry skid register.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid/in_ready        : input beat handshake (transfer when both high)
//   in_result, in_addr       : lane results and pixel address of the beat
//   in_first, in_last        : first / last input channel markers
//   bias_push, bias_in       : bias shift chain (enters at lane LANES-1)
//   relu_en, shift_amt       : requant controls (quasi-static)
//   sp_rd_addr, sp_rd_data   : scratch read (data one cycle after address)
//   sp_wr_en/addr/data       : registered scratch write
//   out_valid/out_ready      : packed output handshake (transfer when both high)
//   out_addr, out_data       : packed output word and its address
//   out_bias_dbg             : lane-0 bias register
module psum_accum_array
    import psum_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int ADDR_W  = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PSUM_W-1:0] in_result,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    bias_push,
    input  logic [PSUM_W-1:0]       bias_in,
    input  logic                    relu_en,
    input  logic [SHIFT_W-1:0]      shift_amt,
    output logic [ADDR_W-1:0]       sp_rd_addr,
    input  logic [LANES*PSUM_W-1:0] sp_rd_data,
    output logic                    sp_wr_en,
    output logic [ADDR_W-1:0]       sp_wr_addr,
    output logic [LANES*PSUM_W-1:0] sp_wr_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic [PSUM_W-1:0]       out_bias_dbg
);

    localparam int RES_W  = LANES * PSUM_W;
    localparam int PACK_W = LANES * OUT_W;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_first_q, s1_first_d;
    logic              s1_last_q,  s1_last_d;
    logic              s1_held_q,  s1_held_d;
    logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
    logic [RES_W-1:0]  s1_result_q, s1_result_d;

    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [RES_W-1:0]  wr_data_q, wr_data_d;
    logic              prv_en_q,   prv_en_d;
    logic [ADDR_W-1:0] prv_addr_q, prv_addr_d;
    logic [RES_W-1:0]  prv_data_q, prv_data_d;

    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
    logic [PACK_W-1:0] out_data_q,  out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0] skid_addr_q,  skid_addr_d;
    logic [PACK_W-1:0] skid_data_q,  skid_data_d;

    logic [PSUM_W-1:0] bias_q [LANES];
    logic [PSUM_W-1:0] bias_d [LANES];

    logic              accept, emit, out_fire, can_take, take, hold;
    logic [RES_W-1:0]  fwd_data;
    logic [RES_W-1:0]  sum_vec;
    logic [PSUM_W-1:0] base;
    logic [PACK_W-1:0] q_vec;

    assign in_ready   = rst && !skid_valid_q;
    assign accept     = in_valid && in_ready;
    assign sp_rd_addr = in_addr;

    // Read data for the S1 beat may be stale: the write registered last cycle
    // (on the bus now) and the one on the bus during the read have not
    // reached memory. The newest matching write wins.
    always_comb begin
        fwd_data = sp_rd_data;
        if (prv_en_q && (prv_addr_q == s1_addr_q)) fwd_data = prv_data_q;
        if (wr_en_q && (wr_addr_q == s1_addr_q))   fwd_data = wr_data_q;
        sum_vec = '0;
        base    = '0;
        for (int l = 0; l < LANES; l++) begin
            // A held beat already folded its base into s1_result_q.
            if (s1_held_q)       base = '0;
            else if (s1_first_q) base = bias_q[l];
            else                 base = fwd_data[lane_lsb(l, PSUM_W) +: PSUM_W];
            sum_vec[lane_lsb(l, PSUM_W) +: PSUM_W] =
                base + s1_result_q[lane_lsb(l, PSUM_W) +: PSUM_W];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_requant
        psum_requant #(
            .PSUM_W  (PSUM_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_requant (
            .sum_in    (sum_vec[g*PSUM_W +: PSUM_W]),
            .relu_en   (relu_en),
            .shift_amt (shift_amt),
            .q_out     (q_vec[g*OUT_W +: OUT_W])
        );
    end

    assign emit     = s1_valid_q && s1_last_q;
    assign out_fire = out_valid_q && out_ready;
    assign can_take = !skid_valid_q || out_fire;
    assign take     = emit && can_take;
    assign hold     = emit && !can_take;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_first_d   = s1_first_q;
        s1_last_d    = s1_last_q;
        s1_held_d    = s1_held_q;
        s1_addr_d    = s1_addr_q;
        s1_result_d  = s1_result_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        bias_d       = bias_q;

        wr_en_d    = s1_valid_q && !s1_last_q;
        wr_addr_d  = s1_addr_q;
        wr_data_d  = sum_vec;
        prv_en_d   = wr_en_q;
        prv_addr_d = wr_addr_q;
        prv_data_d = wr_data_q;

        // A held beat freezes its final sum so the scratch read data can move on.
        if (hold) begin
            s1_held_d   = 1'b1;
            s1_result_d = sum_vec;
        end else begin
            s1_valid_d  = accept;
            s1_first_d  = in_first;
            s1_last_d   = in_last;
            s1_held_d   = 1'b0;
            s1_addr_d   = in_addr;
            s1_result_d = in_result;
        end

        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_addr_d   = skid_addr_q;
                out_data_d   = skid_data_q;
                skid_valid_d = take;
                if (take) begin
                    skid_addr_d = s1_addr_q;
                    skid_data_d = q_vec;
                end
            end else begin
                out_valid_d = take;
                if (take) begin
                    out_addr_d = s1_addr_q;
                    out_data_d = q_vec;
                end
            end
        end else if (take) begin
            skid_valid_d = 1'b1;
            skid_addr_d  = s1_addr_q;
            skid_data_d  = q_vec;
        end

        if (bias_push) begin
            for (int l = 0; l < LANES - 1; l++) bias_d[l] = bias_q[l+1];
            bias_d[LANES-1] = bias_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_held_q    <= 1'b0;
            s1_addr_q    <= '0;
            s1_result_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            prv_en_q     <= 1'b0;
            prv_addr_q   <= '0;
            prv_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            for (int l = 0; l < LANES; l++) bias_q[l] <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_first_q   <= s1_first_d;
            s1_last_q    <= s1_last_d;
            s1_held_q    <= s1_held_d;
            s1_addr_q    <= s1_addr_d;
            s1_result_q  <= s1_result_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            prv_en_q     <= prv_en_d;
            prv_addr_q   <= prv_addr_d;
            prv_data_q   <= prv_data_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            for (int l = 0; l < LANES; l++) bias_q[l] <= bias_d[l];
        end
    end

    assign sp_wr_en     = wr_en_q;
    assign sp_wr_addr   = wr_addr_q;
    assign sp_wr_data   = wr_data_q;
    assign out_valid    = out_valid_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign out_bias_dbg = bias_q[0];

endmodule

// File: doc/psum_accum_array.md
Name: psum_accum_array

Overview:
- Parametrised successor to the fixed 4-lane accumulate/bias/pack path behind the conv engine.
- Accumulates LANES per-lane partial sums into external scratch memory across input channels. A bias shift-chain supplies the first-channel initial value.
- On the last input channel it applies optional ReLU, an arithmetic right shift and signed saturation, then packs the lanes into one output word with a valid/ready handshake.
- Sits between the conv_4U lane array and the output BRAM interface.

Parameters:
- LANES, 4, number of parallel output-channel lanes (1..8).
- PSUM_W, 32, partial-sum and bias width in bits (signed).
- OUT_W, 8, quantised output width per lane (signed); LANES*OUT_W <= 64.
- ADDR_W, 16, scratch and output address width (word address).
- SHIFT_W, 5, width of the requant shift amount.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  lane results valid this cycle.
- in_ready  out  1  block accepts in_* this cycle.
- in_result  in  LANES*PSUM_W  lane results; lane i occupies bits [i*PSUM_W +: PSUM_W].
- in_addr  in  ADDR_W  pixel address, used for both scratch and output.
- in_first  in  1  first input channel: initialise from bias.
- in_last  in  1  last input channel: emit output, skip writeback.
- bias_push  in  1  shift bias_in into lane LANES-1; every lane i takes lane i+1's value.
- bias_in  in  PSUM_W  bias word.
- relu_en  in  1  clamp negatives to 0 before the shift (quasi-static).
- shift_amt  in  SHIFT_W  arithmetic right shift (quasi-static).
- sp_rd_addr  out  ADDR_W  scratch read address; read data arrives 1 cycle later.
- sp_rd_data  in  LANES*PSUM_W  scratch read data.
- sp_wr_en  out  1  scratch write strobe.
- sp_wr_addr  out  ADDR_W  scratch write address.
- sp_wr_data  out  LANES*PSUM_W  scratch write data.
- out_valid  out  1  packed output valid.
- out_ready  in  1  consumer accepts the output.
- out_addr  out  ADDR_W  output word address.
- out_data  out  LANES*OUT_W  packed output; lane i occupies bits [i*OUT_W +: OUT_W].
- out_bias_dbg  out  PSUM_W  lane-0 bias register, for observability.

Behaviour:
- Reset values: all outputs 0, bias registers 0, pipeline empty.
  - in_ready is 1 from the first cycle after reset release.
  - Reset mid-operation discards in-flight beats; no scratch write completes after reset assertion.
- Pipeline stages:
  - S0 accept: a beat transfers when in_valid && in_ready. sp_rd_addr = in_addr combinationally. Register addr, first, last, result.
  - S1 compute, one cycle later: base = first ? bias[i] : fwd_or(sp_rd_data[i]); sum[i] = base + result[i], wrapping at PSUM_W bits.
  - S1, !last: sp_wr_en = 1, sp_wr_addr = addr, sp_wr_data = sum, all registered, so the write is visible 1 cycle after S1.
  - S1, last: no scratch write. Requant each lane: r = relu_en && sum<0 ? 0 : sum; q = r >>> shift_amt; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Load the output register, set out_valid.
- Latency: accept to sp_wr_en is 2 cycles. Accept to out_valid is 2 cycles.
- RAW hazard (back-to-back beats to the same addr):
  - If the scratch write pending in the write register has the same addr as the current S1 read, the write data replaces sp_rd_data.
  - The same applies to a write landing in the same cycle as the read.
  - Forwarding also applies when the first beat was last=0 and the second is last=1.
- Output handshake:
  - out_* stay stable while out_valid && !out_ready.
  - A 1-entry skid register backs the output register.
  - in_ready = !(skid full). With the skid full, a beat arriving in S1 with last is held; its writeback beats still retire.
  - Simultaneous out_ready and a new result: the current output retires and the new one loads in the same cycle; no bubble.
- Bias chain:
  - bias_push has priority over nothing else, since bias is only read in S1.
  - A push in the same cycle as an S1 first-beat read uses the pre-push value.
  - LANES pushes fully load the chain; lane 0 holds the first pushed word.
- first && last together (single input channel): out = requant(bias + result); no scratch access is used.
- No wrap on addresses; the caller guarantees addr < 2^ADDR_W.

Decomposition:
- Package psum_pkg: PSUM_W/OUT_W defaults, lane slice helper functions, and the saturate function sat_shift(value, shift, relu).
- One natural sub-module, psum_requant: combinational per-lane relu/shift/saturate, instantiated LANES times with a generate loop.
- Skid buffer logic stays inline.

Test Plan:
- Bias load then single beat: push biases 10, 20, 30, 40; beat first=last=1, results {1,2,3,4}, shift 0 -> out lanes {11,22,33,44} at cycle +2.
- Three-channel accumulate: addr 5, results 100 each beat, bias 0, shift 2 -> two scratch writes of 100 and 200; out = 75 per lane.
- Saturation/ReLU: sum 1000, shift 1 -> 127; sum -1000 with relu_en=0 -> -128; relu_en=1 -> 0.
- RAW forwarding: back-to-back beats to addr 7 (first, then middle, then last) with result 1 each and bias 0, scratch model returning stale data -> out = 3.
- Backpressure: hold out_ready=0 across two last beats -> second output held in skid, in_ready drops, out_data stable; release -> both outputs delivered in order with no loss.
- Reset mid-stream: assert rst during S1 of a writeback -> sp_wr_en stays 0; out_valid = 0; bias registers cleared.
